// File: rtl/vote_filter.sv
// N-input majority/minority voter with a HOLD-cycle persistence filter on the
// registered result and a saturating count of enabled cycles with split inputs.
module vote_filter #(
  parameter int N    = 3,
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic [N-1:0]  in,
  input  logic          clr,
  output logic          y,
  output logic          valid,
  output logic [CW-1:0] dis_cnt
);

  localparam int CNT_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int WARM_W = $clog2(HOLD + 1);
  localparam int POP_W  = $clog2(N + 1);

  localparam logic [POP_W-1:0]  HALF      = POP_W'(N / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(HOLD - 1);
  localparam logic [CW-1:0]     DIS_MAX   = '1;

  logic [POP_W-1:0]  pop;
  logic              maj;
  logic              raw;
  logic              unanimous;
  logic [CNT_W-1:0]  cnt;
  logic [WARM_W-1:0] warm;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + POP_W'(in[i]);
    end
  end

  // N is odd, so a strict "more than half" compare never ties.
  assign maj       = (pop > HALF);
  assign raw       = mode ? ~maj : maj;
  assign unanimous = (in == '0) || (in == '1);

  // Persistence filter: y follows raw only after HOLD consecutive enabled
  // disagreements; any enabled agreement discards the pending run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= 1'b0;
      cnt   <= '0;
      warm  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      if (raw == y) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        y   <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (!valid) begin
        warm <= warm + 1'b1;
        if (warm == WARM_LAST) begin
          valid <= 1'b1;
        end
      end
    end
  end

  // clr acts regardless of en and takes priority over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dis_cnt <= '0;
    end else if (clr) begin
      dis_cnt <= '0;
    end else if (en && !unanimous && (dis_cnt != DIS_MAX)) begin
      dis_cnt <= dis_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vote_filter.sv
// Directed bench for vote_filter (N=3, HOLD=4, CW=4): a history-based model is
// compared on every falling edge, plus hand-computed literal checkpoints.
module tb_vote_filter;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int CW   = 4;
  localparam int DMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [N-1:0]  in_v;
  logic          clr;
  logic          y;
  logic          valid;
  logic [CW-1:0] dis_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: recent enabled raw votes, enabled-edge count, split count.
  logic m_y     = 1'b0;
  int   m_edges = 0;
  int   m_dis   = 0;
  logic hist[$];

  vote_filter #(.N(N), .HOLD(HOLD), .CW(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .in     (in_v),
    .clr    (clr),
    .y      (y),
    .valid  (valid),
    .dis_cnt(dis_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: y flips once the last HOLD enabled raw votes all differ from it.
  always @(negedge rst_n) begin
    m_y     = 1'b0;
    m_edges = 0;
    m_dis   = 0;
    hist.delete();
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      logic r;
      logic all_diff;
      r = mode ^ ($countones(in_v) > N / 2);
      if (clr) m_dis = 0;
      else if (en && in_v != '0 && in_v != '1 && m_dis < DMAX) m_dis = m_dis + 1;
      if (en) begin
        hist.push_back(r);
        if (hist.size() > HOLD) void'(hist.pop_front());
        if (m_edges < HOLD) m_edges = m_edges + 1;
        if (hist.size() == HOLD) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k] == m_y) all_diff = 1'b0;
          if (all_diff) m_y = r;
        end
      end
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    checks = checks + 1;
    if (y !== m_y || valid !== (m_edges >= HOLD) || dis_cnt !== CW'(m_dis)) begin
      failures = failures + 1;
      $display("FAIL model_cmp t=%0t y=%b/%b valid=%b/%b dis_cnt=%0d/%0d (got/exp)",
               $time, y, m_y, valid, (m_edges >= HOLD), dis_cnt, m_dis);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs, take one rising edge, settle 1 time unit after it.
  task automatic cyc(input logic e, input logic m, input logic [N-1:0] v, input logic c);
    en   = e;
    mode = m;
    in_v = v;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input int n, input logic e, input logic m, input logic [N-1:0] v);
    for (int i = 0; i < n; i++) cyc(e, m, v, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    in_v  = 3'b101;
    clr   = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_y", y, 0);
    chk("reset_valid", valid, 0);
    chk("reset_dis", dis_cnt, 0);
    rst_n = 1'b1;

    // Warm-up with a persistent majority of 1
    rep(3, 1'b1, 1'b0, 3'b101);
    chk("warm_y_e3", y, 0);
    chk("warm_valid_e3", valid, 0);
    rep(1, 1'b1, 1'b0, 3'b101);
    chk("warm_y_e4", y, 1);
    chk("warm_valid_e4", valid, 1);
    chk("warm_dis_e4", dis_cnt, 4);

    // A 3-edge glitch is discarded; a 4-edge run goes through
    rep(1, 1'b1, 1'b0, 3'b111);
    rep(3, 1'b1, 1'b0, 3'b001);
    rep(1, 1'b1, 1'b0, 3'b111);
    chk("glitch_y", y, 1);
    rep(3, 1'b1, 1'b0, 3'b001);
    chk("run_y_e3", y, 1);
    rep(1, 1'b1, 1'b0, 3'b001);
    chk("run_y_e4", y, 0);
    chk("run_dis", dis_cnt, 11);

    // Minority mode, then a mode flip filtered like any other raw change
    rep(1, 1'b1, 1'b1, 3'b111);
    chk("minor_111_y", y, 0);
    rep(4, 1'b1, 1'b1, 3'b000);
    chk("minor_000_y", y, 1);
    rep(3, 1'b1, 1'b0, 3'b000);
    chk("mode_flip_y_e3", y, 1);
    rep(1, 1'b1, 1'b0, 3'b000);
    chk("mode_flip_y_e4", y, 0);
    chk("mode_dis", dis_cnt, 11);

    // Disabled edges neither advance nor break a pending run
    rep(2, 1'b1, 1'b0, 3'b011);
    rep(5, 1'b0, 1'b0, 3'b011);
    chk("en0_y", y, 0);
    chk("en0_dis", dis_cnt, 13);
    rep(1, 1'b1, 1'b0, 3'b011);
    chk("en_resume_y1", y, 0);
    rep(1, 1'b1, 1'b0, 3'b011);
    chk("en_resume_y2", y, 1);
    chk("en_resume_dis", dis_cnt, 15);

    // Saturation and clear priority
    cyc(1'b1, 1'b0, 3'b110, 1'b1);
    chk("clr_wins", dis_cnt, 0);
    rep(20, 1'b1, 1'b0, 3'b110);
    chk("sat_dis", dis_cnt, 15);
    cyc(1'b1, 1'b0, 3'b110, 1'b1);
    chk("clr_dis", dis_cnt, 0);
    chk("clr_y", y, 1);
    rep(3, 1'b0, 1'b0, 3'b110);
    cyc(1'b0, 1'b0, 3'b110, 1'b1);
    chk("clr_en0_dis", dis_cnt, 0);

    // Asynchronous reset in the middle of a pending run
    rep(7, 1'b1, 1'b0, 3'b110);
    rep(2, 1'b1, 1'b0, 3'b000);
    chk("pre_rst_y", y, 1);
    chk("pre_rst_dis", dis_cnt, 7);
    rst_n = 1'b0;
    #2;
    chk("async_rst_y", y, 0);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_dis", dis_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rep(3, 1'b1, 1'b0, 3'b101);
    chk("rewarm_valid_e3", valid, 0);
    rep(1, 1'b1, 1'b0, 3'b101);
    chk("rewarm_valid_e4", valid, 1);
    chk("rewarm_y_e4", y, 1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
